// File: rtl/func_arbiter.sv
// Round-robin arbiter sharing one func evaluator among NUM_REQ requesters.
// Each transaction runs WAIT (with timeout), then DRAIN (discards a lingering f_done), then RESP.
module func_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  logic [16*NUM_REQ-1:0]   req_a,
  input  logic [16*NUM_REQ-1:0]   req_b,
  input  logic [16*NUM_REQ-1:0]   req_c,
  input  logic [16*NUM_REQ-1:0]   req_d,
  output logic [NUM_REQ-1:0]      req_ready,
  output logic [NUM_REQ-1:0]      rsp_valid,
  output logic [31:0]             rsp_z,
  output logic                    rsp_overflow,
  output logic                    rsp_timeout,
  output logic                    busy,
  output logic                    f_start,
  output logic [15:0]             f_a,
  output logic [15:0]             f_b,
  output logic [15:0]             f_c,
  output logic [15:0]             f_d,
  input  logic [31:0]             f_z,
  input  logic                    f_done,
  input  logic                    f_overflow
);
  localparam int IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int IDX_W1 = IDX_W + 1;
  localparam int CNT_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [IDX_W1-1:0] NUM_REQ_W   = IDX_W1'(NUM_REQ);
  localparam logic [CNT_W-1:0]  CNT_LAST    = CNT_W'(TIMEOUT - 1);
  localparam logic [IDX_W-1:0]  LAST_REQ    = IDX_W'(NUM_REQ - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] WAIT  = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] RESP  = 2'd3;

  logic [1:0]         state_q, state_d;
  logic [IDX_W-1:0]   grant_q, grant_d;
  logic [IDX_W-1:0]   last_grant_q, last_grant_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               f_start_q, f_start_d;
  logic [15:0]        f_a_q, f_a_d, f_b_q, f_b_d, f_c_q, f_c_d, f_d_q, f_d_d;
  logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
  logic [31:0]        rsp_z_q, rsp_z_d;
  logic               rsp_ovf_q, rsp_ovf_d;
  logic               rsp_to_q, rsp_to_d;

  logic [IDX_W1-1:0]  cand_s;
  logic [IDX_W-1:0]   pick_s;
  logic               found_s;
  logic [15:0]        sel_a_s, sel_b_s, sel_c_s, sel_d_s;

  // Round-robin search; walking offsets downward lets the nearest valid index win.
  always_comb begin
    found_s = 1'b0;
    pick_s  = last_grant_q;
    cand_s  = '0;
    for (int off = NUM_REQ; off >= 1; off--) begin
      cand_s  = {1'b0, last_grant_q} + IDX_W1'(off);
      cand_s  = (cand_s >= NUM_REQ_W) ? (cand_s - NUM_REQ_W) : cand_s;
      found_s = found_s | req_valid[cand_s[IDX_W-1:0]];
      pick_s  = req_valid[cand_s[IDX_W-1:0]] ? cand_s[IDX_W-1:0] : pick_s;
    end
  end

  // Operand mux for the candidate requester.
  always_comb begin
    sel_a_s = 16'h0000;
    sel_b_s = 16'h0000;
    sel_c_s = 16'h0000;
    sel_d_s = 16'h0000;
    for (int i = 0; i < NUM_REQ; i++) begin
      sel_a_s = (pick_s == IDX_W'(i)) ? req_a[16*i +: 16] : sel_a_s;
      sel_b_s = (pick_s == IDX_W'(i)) ? req_b[16*i +: 16] : sel_b_s;
      sel_c_s = (pick_s == IDX_W'(i)) ? req_c[16*i +: 16] : sel_c_s;
      sel_d_s = (pick_s == IDX_W'(i)) ? req_d[16*i +: 16] : sel_d_s;
    end
  end

  // Transaction sequencing.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    f_start_d    = f_start_q;
    f_a_d        = f_a_q;
    f_b_d        = f_b_q;
    f_c_d        = f_c_q;
    f_d_d        = f_d_q;
    rsp_valid_d  = '0;
    rsp_z_d      = rsp_z_q;
    rsp_ovf_d    = rsp_ovf_q;
    rsp_to_d     = rsp_to_q;
    case (state_q)
      IDLE: begin
        if (found_s) begin
          state_d   = WAIT;
          grant_d   = pick_s;
          cnt_d     = '0;
          f_start_d = 1'b1;
          f_a_d     = sel_a_s;
          f_b_d     = sel_b_s;
          f_c_d     = sel_c_s;
          f_d_d     = sel_d_s;
        end else begin
          f_start_d = 1'b0;
        end
      end
      WAIT: begin
        // Completion takes priority over a coincident timeout.
        if (f_done) begin
          state_d   = DRAIN;
          f_start_d = 1'b0;
          rsp_z_d   = f_z;
          rsp_ovf_d = f_overflow;
          rsp_to_d  = 1'b0;
        end else if (cnt_q == CNT_LAST) begin
          state_d   = DRAIN;
          f_start_d = 1'b0;
          rsp_z_d   = 32'h0000_0000;
          rsp_ovf_d = 1'b0;
          rsp_to_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DRAIN: begin
        if (!f_done) begin
          state_d     = RESP;
          rsp_valid_d = NUM_REQ'(1) << grant_q;
        end else begin
          state_d = DRAIN;
        end
      end
      RESP: begin
        state_d      = IDLE;
        last_grant_d = grant_q;
      end
      default: begin
        state_d   = IDLE;
        f_start_d = 1'b0;
      end
    endcase
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      last_grant_q <= LAST_REQ;
      cnt_q        <= '0;
      f_start_q    <= 1'b0;
      f_a_q        <= 16'h0000;
      f_b_q        <= 16'h0000;
      f_c_q        <= 16'h0000;
      f_d_q        <= 16'h0000;
      rsp_valid_q  <= '0;
      rsp_z_q      <= 32'h0000_0000;
      rsp_ovf_q    <= 1'b0;
      rsp_to_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
      f_start_q    <= f_start_d;
      f_a_q        <= f_a_d;
      f_b_q        <= f_b_d;
      f_c_q        <= f_c_d;
      f_d_q        <= f_d_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_z_q      <= rsp_z_d;
      rsp_ovf_q    <= rsp_ovf_d;
      rsp_to_q     <= rsp_to_d;
    end
  end

  // req_ready is gated by rst_n so it drops the instant reset asserts.
  assign req_ready    = (rst_n && state_q == IDLE && found_s) ? (NUM_REQ'(1) << pick_s) : '0;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_z        = rsp_z_q;
  assign rsp_overflow = rsp_ovf_q;
  assign rsp_timeout  = rsp_to_q;
  assign busy         = (state_q != IDLE);
  assign f_start      = f_start_q;
  assign f_a          = f_a_q;
  assign f_b          = f_b_q;
  assign f_c          = f_c_q;
  assign f_d          = f_d_q;

endmodule

// File: tb/tb_func_arbiter.sv
// Bench for func_arbiter: directed scenarios then randomized traffic checked
// against a transaction-level round-robin / latency model.
module tb_func_arbiter;
  localparam int N  = 4;
  localparam int TO = 32;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    req_valid = '0;
  logic [16*N-1:0] req_a = '0, req_b = '0, req_c = '0, req_d = '0;
  logic [N-1:0]    req_ready, rsp_valid;
  logic [31:0]     rsp_z;
  logic            rsp_overflow, rsp_timeout, busy, f_start;
  logic [15:0]     f_a, f_b, f_c, f_d;
  logic [31:0]     f_z;
  logic            f_done = 1'b0;
  logic            f_overflow;

  logic [15:0] op_a [N];
  logic [15:0] op_b [N];
  logic [15:0] op_c [N];
  logic [15:0] op_d [N];

  int n_pass = 0, n_total = 0, n_fail = 0;
  int last_m = N - 1;
  int fm_hi = 0, fm_lo = 0, fm_extra = 0;
  bit fm_never = 1'b0;

  func_arbiter #(.NUM_REQ(N), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid),
    .req_a(req_a), .req_b(req_b), .req_c(req_c), .req_d(req_d),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_z(rsp_z),
    .rsp_overflow(rsp_overflow), .rsp_timeout(rsp_timeout), .busy(busy),
    .f_start(f_start), .f_a(f_a), .f_b(f_b), .f_c(f_c), .f_d(f_d),
    .f_z(f_z), .f_done(f_done), .f_overflow(f_overflow)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] model_z(input logic [15:0] a, b, c, d);
    if (a == 16'h0300 && b == 16'h0100 && c == 16'h0000 && d == 16'h0100) return 32'h0000_0300;
    return {a ^ d, b + c};
  endfunction

  function automatic logic model_ovf(input logic [15:0] a, b);
    return a[15] ^ b[0];
  endfunction

  function automatic int rr_pick(input int last, input logic [N-1:0] v);
    for (int k = 1; k <= N; k++) if (v[(last + k) % N]) return (last + k) % N;
    return -1;
  endfunction

  function automatic logic [N-1:0] onehot(input int i);
    if (i < 0 || i >= N) return '0;
    return N'(1) << i;
  endfunction

  assign f_z        = model_z(f_a, f_b, f_c, f_d);
  assign f_overflow = model_ovf(f_a, f_b);

  // Func evaluator model: done 6 cycles after start rises, drops 2+extra cycles after start falls.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fm_hi <= 0; fm_lo <= 0; f_done <= 1'b0;
    end else if (f_start) begin
      fm_lo <= 0;
      fm_hi <= fm_hi + 1;
      if (!fm_never && fm_hi + 1 >= 6) f_done <= 1'b1;
    end else begin
      fm_hi <= 0;
      if (f_done) begin
        if (fm_lo + 1 >= 2 + fm_extra) begin
          f_done <= 1'b0; fm_lo <= 0;
        end else begin
          fm_lo <= fm_lo + 1;
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pack();
    for (int i = 0; i < N; i++) begin
      req_a[16*i +: 16] = op_a[i];
      req_b[16*i +: 16] = op_b[i];
      req_c[16*i +: 16] = op_c[i];
      req_d[16*i +: 16] = op_d[i];
    end
  endtask

  task automatic raise(input int i);
    if (!req_valid[i]) begin
      op_a[i] = 16'($urandom); op_b[i] = 16'($urandom);
      op_c[i] = 16'($urandom); op_d[i] = 16'($urandom);
      req_valid[i] = 1'b1;
      pack();
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    last_m = N - 1;
    #1;
  endtask

  // One full transaction: grant, latched operands, response latency and payload.
  task automatic serve_one(input int exp_idx, input int extra, input bit never, input bit drop);
    int g, lat;
    logic [15:0] ea, eb, ec, ed;
    logic [31:0] ez;
    logic eo, et;
    fm_extra = extra;
    fm_never = never;
    #1;
    g = (exp_idx >= 0) ? exp_idx : rr_pick(last_m, req_valid);
    lat = 0;
    while (req_ready == '0 && lat < 100) begin @(posedge clk); #1; lat++; end
    chk("grant_onehot", 32'(req_ready), 32'(onehot(g)));
    chk("idle_not_busy", 32'(busy), 32'd0);
    if (g < 0) g = 0;
    ea = op_a[g]; eb = op_b[g]; ec = op_c[g]; ed = op_d[g];
    @(posedge clk); #1;
    chk("f_start_t1", 32'(f_start), 32'd1);
    chk("busy_t1", 32'(busy), 32'd1);
    chk("ready_low_t1", 32'(req_ready), 32'd0);
    chk("f_a", 32'(f_a), 32'(ea));
    chk("f_d", 32'(f_d), 32'(ed));
    if (drop) begin
      req_valid[g] = 1'b0;
      op_a[g] = 16'($urandom); op_b[g] = 16'($urandom);
      op_c[g] = 16'($urandom); op_d[g] = 16'($urandom);
      pack();
    end
    lat = 1;
    while (rsp_valid == '0 && lat < 80) begin @(posedge clk); #1; lat++; end
    if (never) begin ez = 32'h0; eo = 1'b0; et = 1'b1; end
    else begin ez = model_z(ea, eb, ec, ed); eo = model_ovf(ea, eb); et = 1'b0; end
    chk("rsp_latency", 32'(lat), never ? 32'(TO + 2) : 32'(11 + extra));
    chk("rsp_valid_idx", 32'(rsp_valid), 32'(onehot(g)));
    chk("rsp_z", rsp_z, ez);
    chk("rsp_overflow", 32'(rsp_overflow), 32'(eo));
    chk("rsp_timeout", 32'(rsp_timeout), 32'(et));
    chk("f_b_held", 32'(f_b), 32'(eb));
    chk("f_c_held", 32'(f_c), 32'(ec));
    last_m = g;
    @(posedge clk); #1;
    chk("rsp_one_cycle", 32'(rsp_valid), 32'd0);
    chk("back_idle", 32'(busy), 32'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // Reset values, with a request already pending.
    op_a[0] = 16'h0300; op_b[0] = 16'h0100; op_c[0] = 16'h0000; op_d[0] = 16'h0100;
    for (int i = 1; i < N; i++) begin
      op_a[i] = 16'h0; op_b[i] = 16'h0; op_c[i] = 16'h0; op_d[i] = 16'h0;
    end
    req_valid[0] = 1'b1;
    pack();
    @(posedge clk); @(posedge clk); #1;
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_f_start", 32'(f_start), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_z", rsp_z, 32'd0);
    chk("rst_rsp_timeout", 32'(rsp_timeout), 32'd0);
    chk("rst_f_a", 32'(f_a), 32'd0);
    rst_n = 1'b1;
    #1;

    // Single request with the reference operands.
    serve_one(0, 0, 1'b0, 1'b1);

    // All requesters pending from reset.
    req_valid = '0;
    for (int i = 0; i < N; i++) raise(i);
    do_reset();
    serve_one(0, 0, 1'b0, 1'b0);
    serve_one(1, 0, 1'b0, 1'b0);
    serve_one(2, 0, 1'b0, 1'b0);
    serve_one(3, 0, 1'b0, 1'b0);
    serve_one(0, 0, 1'b0, 1'b0);

    // Fairness between two permanent requesters.
    req_valid = '0;
    raise(1); raise(3);
    do_reset();
    serve_one(1, 0, 1'b0, 1'b0);
    serve_one(3, 0, 1'b0, 1'b0);
    serve_one(1, 0, 1'b0, 1'b0);
    serve_one(3, 0, 1'b0, 1'b0);

    // Timeout followed by a normal transaction.
    req_valid = '0;
    raise(2);
    do_reset();
    serve_one(2, 0, 1'b1, 1'b1);
    raise(1);
    serve_one(1, 0, 1'b0, 1'b1);

    // Stale done held 5 extra cycles, then a normal transaction.
    raise(3);
    serve_one(3, 5, 1'b0, 1'b1);
    raise(0);
    serve_one(0, 0, 1'b0, 1'b1);

    // Reset in the middle of WAIT.
    req_valid = '0;
    fm_never = 1'b0; fm_extra = 0;
    raise(2);
    #1;
    chk("mid_grant", 32'(req_ready), 32'(onehot(rr_pick(last_m, req_valid))));
    repeat (4) begin @(posedge clk); #1; end
    chk("mid_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_f_start", 32'(f_start), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_ready", 32'(req_ready), 32'd0);
    raise(0);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk("mid_rst_no_rsp", 32'(rsp_valid), 32'd0);
    end
    rst_n = 1'b1;
    last_m = N - 1;
    #1;
    serve_one(0, 0, 1'b0, 1'b1);
    serve_one(2, 0, 1'b0, 1'b1);

    // Randomized traffic.
    for (int t = 0; t < 25; t++) begin
      int r;
      for (int i = 0; i < N; i++) if ($urandom_range(0, 2) == 0) raise(i);
      if (req_valid == '0) raise(int'($urandom_range(0, N - 1)));
      r = int'($urandom_range(0, 9));
      serve_one(-1, (r >= 7) ? int'($urandom_range(1, 5)) : 0, (r == 0), 1'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
